// File: rtl/router_out_arbiter.sv
// Round-robin arbiter sharing one router output port between NUM_IN inputs,
// forwarding the granted packet over a registered 4-phase req/ack handshake.

module router_out_arbiter_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

module router_out_arbiter #(
  parameter int WIDTH_packet = 14,
  parameter int NUM_IN       = 2,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0]              in_req,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic [NUM_IN-1:0]              in_ack,
  output logic                           out_req,
  output logic [WIDTH_packet-1:0]        out_data,
  input  logic                           out_ack,
  output logic [$clog2(NUM_IN)-1:0]      grant_id,
  output logic                           busy,
  output logic [NUM_IN*CNT_W-1:0]        pkt_cnt
);
  localparam int GW = $clog2(NUM_IN);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RTZ} state_t;

  state_t                                 state, state_nxt;
  logic [GW-1:0]                          ptr, ptr_nxt, grant_nxt, pick;
  logic                                   any_req, out_req_nxt;
  logic [WIDTH_packet-1:0]                out_data_nxt;
  logic [NUM_IN-1:0]                      ack_nxt, inc;
  logic [NUM_IN-1:0][WIDTH_packet-1:0]    data_arr;
  logic [NUM_IN-1:0][CNT_W-1:0]           cnt_arr;

  assign data_arr = in_data;
  assign pkt_cnt  = cnt_arr;
  assign busy     = (state != IDLE);

  // Scan offsets from farthest to nearest so the input closest to ptr wins.
  always_comb begin
    logic [GW:0] s;
    s       = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (GW+1)'(k);
      if (s >= (GW+1)'(NUM_IN)) s = s - (GW+1)'(NUM_IN);
      if (in_req[s[GW-1:0]]) begin
        pick    = s[GW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    out_req_nxt  = out_req;
    out_data_nxt = out_data;
    grant_nxt    = grant_id;
    ack_nxt      = in_ack;
    ptr_nxt      = ptr;
    inc          = '0;
    case (state)
      IDLE: begin
        // A stale out_ack from the previous transfer blocks any new grant.
        if (!out_ack && any_req) begin
          out_data_nxt = data_arr[pick];
          grant_nxt    = pick;
          out_req_nxt  = 1'b1;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (out_ack) begin
          out_req_nxt       = 1'b0;
          ack_nxt[grant_id] = 1'b1;
          state_nxt         = WAIT_RTZ;
        end
      end
      WAIT_RTZ: begin
        if (!out_ack && !in_req[grant_id]) begin
          ack_nxt       = '0;
          inc[grant_id] = 1'b1;
          ptr_nxt       = (grant_id == GW'(NUM_IN - 1)) ? '0 : grant_id + 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      in_ack   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      out_req  <= out_req_nxt;
      out_data <= out_data_nxt;
      in_ack   <= ack_nxt;
      grant_id <= grant_nxt;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    router_out_arbiter_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .cnt   (cnt_arr[i])
    );
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: source/sink handshake agents, a grant
// scoreboard, and a twin instance with 2-bit counters for wrap checking.

module tb_router_out_arbiter;
  localparam int W = 14;
  localparam int N = 2;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ack, w_in_ack;
  logic           out_req, w_out_req;
  logic [W-1:0]   out_data, w_out_data;
  logic           out_ack, ack_s, ack_force;
  logic [0:0]     grant_id, w_grant_id;
  logic           busy, w_busy;
  logic [N*16-1:0] pkt_cnt;
  logic [N*2-1:0]  pkt_cnt_w;

  int           src_total[N], src_done[N], ack_pulses[N];
  logic [W-1:0] src_data[N];
  int           ack_dly, rel_dly;
  bit           sink_en;
  int           n_chk, n_fail;
  exp_t         q[$];

  assign out_ack = ack_s | ack_force;

  always #5 clk = ~clk;

  router_out_arbiter #(.WIDTH_packet(W), .NUM_IN(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .grant_id(grant_id),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  router_out_arbiter #(.WIDTH_packet(W), .NUM_IN(N), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(w_in_ack),
    .out_req(w_out_req), .out_data(w_out_data), .out_ack(out_ack), .grant_id(w_grant_id),
    .busy(w_busy), .pkt_cnt(pkt_cnt_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_req"},  out_req,   0);
    chk({tag, "_out_data"}, out_data,  0);
    chk({tag, "_in_ack"},   in_ack,    0);
    chk({tag, "_grant_id"}, grant_id,  0);
    chk({tag, "_busy"},     busy,      0);
    chk({tag, "_pkt_cnt"},  pkt_cnt,   0);
    chk({tag, "_pkt_cnt_w"}, pkt_cnt_w, 0);
  endtask

  // Source: raise req with data, drop on ack, re-arm once ack returns to zero.
  task automatic src_agent();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) in_req[i] = 1'b0;
        else if (!in_req[i]) begin
          if (!in_ack[i] && src_done[i] < src_total[i]) begin
            in_data[i*W +: W] = src_data[i];
            in_req[i] = 1'b1;
          end
        end else if (in_ack[i]) begin
          in_req[i] = 1'b0;
          src_done[i]++;
        end
      end
    end
  endtask

  task automatic sink_agent();
    int cnt = 0;
    bit st = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_s = 1'b0; st = 1'b0; cnt = 0;
      end else if (!st) begin
        if (sink_en && out_req) begin
          if (cnt >= ack_dly) begin ack_s = 1'b1; st = 1'b1; cnt = 0; end
          else cnt++;
        end
      end else if (!out_req) begin
        if (cnt >= rel_dly) begin ack_s = 1'b0; st = 1'b0; cnt = 0; end
        else cnt++;
      end
    end
  endtask

  task automatic monitor();
    logic prev_req = 1'b0;
    logic [N-1:0] prev_ack = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_req && !prev_req) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_grant_id", grant_id, e.id);
          chk("sb_out_data", out_data, e.data);
        end
      end
      chk("ack_onehot0", $onehot0(in_ack), 1);
      chk("twin_match", {w_out_req, w_out_data, w_in_ack, w_grant_id, w_busy},
                        {out_req, out_data, in_ack, grant_id, busy});
      for (int i = 0; i < N; i++)
        if (in_ack[i] && !prev_ack[i]) ack_pulses[i]++;
      prev_req = out_req;
      prev_ack = in_ack;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(src_done[0] == src_total[0] && src_done[1] == src_total[1] &&
             in_req == '0 && !busy && !out_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) src_total[i] = src_done[i];
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ack_pulses[i] = 0;
  endtask

  initial begin
    int n;
    in_req = '0; in_data = '0; ack_s = 1'b0; ack_force = 1'b0;
    sink_en = 1'b1; ack_dly = 2; rel_dly = 1;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < N; i++) begin
      src_total[i] = 0; src_done[i] = 0; ack_pulses[i] = 0; src_data[i] = '0;
    end
    fork
      src_agent();
      sink_agent();
      monitor();
    join_none

    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // Single packet from input 0
    @(negedge clk);
    src_data[0] = 14'b01010111111110;
    push(0, 14'b01010111111110);
    src_total[0]++;
    wait_idle("single", 100);
    chk("single_out_data", out_data, 14'b01010111111110);
    chk("single_ack_pulses", ack_pulses[0], 1);
    chk("single_pkt_cnt0", pkt_cnt[15:0], 1);
    chk("single_grant_id", grant_id, 0);
    chk("single_busy", busy, 0);

    // Contention: both inputs, 4 packets each, alternating from input 0
    reset_dut();
    ack_dly = 0; rel_dly = 0;
    for (int k = 0; k < 4; k++) begin
      push(0, 14'h15FE);
      push(1, 14'h17FD);
    end
    src_data[0] = 14'h15FE;
    src_data[1] = 14'h17FD;
    src_total[0] += 4;
    src_total[1] += 4;
    wait_idle("cont", 400);
    chk("cont_pkt_cnt", pkt_cnt, 32'h0004_0004);
    chk("cont_pkt_cnt_w", pkt_cnt_w, 4'h0);
    chk("cont_pulses0", ack_pulses[0], 4);
    chk("cont_pulses1", ack_pulses[1], 4);

    // Stale acknowledge blocks the grant until it falls
    ack_dly = 1; rel_dly = 1;
    @(negedge clk);
    ack_force = 1'b1;
    src_data[1] = 14'h1234;
    push(1, 14'h1234);
    src_total[1]++;
    repeat (5) begin
      @(negedge clk);
      chk("stale_out_req", out_req, 0);
      chk("stale_busy", busy, 0);
    end
    ack_force = 1'b0;
    @(negedge clk);
    chk("stale_grant", out_req, 1);
    wait_idle("stale", 100);
    chk("stale_pkt_cnt1", pkt_cnt[31:16], 5);

    // Back-pressure: out_ack held low for 20 cycles
    sink_en = 1'b0; ack_dly = 0;
    src_data[0] = 14'h2A5A;
    push(0, 14'h2A5A);
    src_total[0]++;
    n = 0;
    while (!out_req && n < 10) begin @(negedge clk); n++; end
    chk("bp_req_timeout", n < 10, 1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_req", out_req, 1);
      chk("bp_out_data", out_data, 14'h2A5A);
      chk("bp_in_ack", in_ack, 0);
    end
    sink_en = 1'b1;
    wait_idle("bp", 100);
    chk("bp_pkt_cnt0", pkt_cnt[15:0], 5);

    // Reset during WAIT_RTZ, then both request: input 0 must win
    rel_dly = 10;
    src_data[0] = 14'h0F0F;
    push(0, 14'h0F0F);
    src_total[0]++;
    n = 0;
    while (!in_ack[0] && n < 20) begin @(negedge clk); n++; end
    chk("mid_ack_timeout", n < 20, 1);
    for (int i = 0; i < N; i++) src_total[i] = src_done[i];
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_reset("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel_dly = 0;
    for (int i = 0; i < N; i++) ack_pulses[i] = 0;
    src_data[0] = 14'h0111;
    src_data[1] = 14'h0222;
    push(0, 14'h0111);
    push(1, 14'h0222);
    src_total[0]++;
    src_total[1]++;
    wait_idle("mid_after", 100);
    chk("mid_pkt_cnt", pkt_cnt, 32'h0001_0001);

    // Counter wrap on the 2-bit twin: 5 packets from input 1
    reset_dut();
    src_data[1] = 14'h0ABC;
    for (int k = 0; k < 5; k++) push(1, 14'h0ABC);
    src_total[1] += 5;
    wait_idle("wrap", 300);
    chk("wrap_pkt_cnt1", pkt_cnt[31:16], 5);
    chk("wrap_pkt_cnt0", pkt_cnt[15:0], 0);
    chk("wrap_pkt_cnt_w1", pkt_cnt_w[3:2], 1);
    chk("wrap_pkt_cnt_w0", pkt_cnt_w[1:0], 0);
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Clocked round-robin arbiter that shares one tree-NoC router output port (parent_out, child1_out or child2_out) between the router inputs that route to it. It grants one input at a time and forwards its WIDTH_packet-bit packet to the output over a registered 4-phase req/ack handshake. It acknowledges the granted input only after the downstream side has accepted the packet. One instance sits in front of each router output; packet contents are not interpreted.

## Interface
- WIDTH_packet, 14: packet width in bits.
- NUM_IN, 2: number of requesting inputs; legal range 2..4.
- CNT_W, 16: width of each per-input delivered-packet counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_req  in  NUM_IN  per-input 4-phase request; synchronous to clk.
- in_data  in  NUM_IN*WIDTH_packet  packet of input i in bits [i*WIDTH_packet +: WIDTH_packet]; stable while in_req[i]=1.
- in_ack  out  NUM_IN  per-input acknowledge, one-hot or zero.
- out_req  out  1  output request.
- out_data  out  WIDTH_packet  registered output packet.
- out_ack  in  1  downstream acknowledge.
- grant_id  out  $clog2(NUM_IN)  index of the current/last granted input.
- busy  out  1  high in any state other than IDLE.
- pkt_cnt  out  NUM_IN*CNT_W  delivered-packet count per input, same packing as in_data.

## Operation
- FSM states: IDLE, SEND, WAIT_RTZ.
- Round-robin pointer ptr (range 0..NUM_IN-1); reset value 0.
- IDLE
  - Entry is allowed only when out_ack=0. If out_ack=1 is sampled in IDLE (stale acknowledge), no grant is made.
  - If any in_req bit is 1, g is the first set index searching ptr, ptr+1, … modulo NUM_IN.
  - Registered actions: out_data<=in_data[g], grant_id<=g, out_req<=1, state<=SEND.
- SEND
  - Hold out_req=1 and out_data until out_ack=1 is sampled.
  - Then: out_req<=0, in_ack[g]<=1, state<=WAIT_RTZ.
- WAIT_RTZ
  - Wait until out_ack=0 and in_req[g]=0 are sampled in the same cycle.
  - Then: in_ack[g]<=0, pkt_cnt[g]<=pkt_cnt[g]+1 (wraps at 2^CNT_W), ptr<=(g+1) mod NUM_IN, state<=IDLE.
- Inputs other than g are ignored while busy. Their in_req may rise or fall freely, and their data is never sampled.
- If in_req[g] falls during SEND (protocol violation), the arbiter does not react. The packet completes, and in_ack[g] still pulses.
- out_data keeps the last packet after completion; it is not cleared.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE, ptr=0, out_req=0, out_data=0, in_ack=0, grant_id=0, busy=0, all pkt_cnt=0.
- Reset mid-transfer aborts the packet silently. No ack is issued, and the counter is not incremented.
- Latency:
  - in_req[g] sampled high at edge t (arbiter idle, out_ack=0) → out_req=1 and out_data valid after edge t.
  - out_ack sampled high at edge t+k → out_req=0 and in_ack[g]=1 after that edge.
  - Completion edge → in_ack=0 and busy=0.
- Minimum 3 cycles per packet with zero-delay peers. The next grant is sampled at the edge after returning to IDLE.
- Simultaneous requests are resolved purely by ptr. With NUM_IN=2 and both inputs continuously requesting, grants alternate 0,1,0,1.
- Request arriving in the same cycle as completion: not seen until the IDLE cycle.
- busy is combinationally equal to (state≠IDLE).

## Test plan
- Single packet: reset, then in_req[0]=1 with in_data[0]=14'b01010111111110; downstream acks after 2 cycles and releases 1 cycle later.
  - Required: out_data=14'b01010111111110, in_ack[0] pulses once, pkt_cnt[0]=1, grant_id=0, busy=0 at end.
- Contention: both inputs hold requests with 14'h15FE and 14'h17FD for 4 packets each.
  - Required: output order 0,1,0,1,…; pkt_cnt={4,4}; in_ack is never high on both inputs.
- Back-pressure: out_ack held low for 20 cycles after out_req rises.
  - Required: out_req and out_data stay stable all 20 cycles; no in_ack is asserted.
- Stale ack: out_ack=1 while idle and in_req[1]=1.
  - Required: no out_req until out_ack falls; the grant follows one edge after.
- Reset mid-operation: assert rst_n=0 during WAIT_RTZ.
  - Required: all outputs go to reset values immediately; pkt_cnt=0; after release, a fresh request is granted starting at input 0.
- Counter wrap with CNT_W=2: send 5 packets from input 1.
  - Required: pkt_cnt[1] reads 1.
